// File: rtl/ibex_rf_fpga_pkg.sv
// rtl/ibex_rf_fpga_pkg.sv - shared types and helpers for the multi-port FPGA register file
// Provides the clear/ready state encoding, the architectural address width
// and the entry count for RV32I/RV32E builds.
package ibex_rf_fpga_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int unsigned RF_ADDR_W = 5;

  function automatic int unsigned num_words(input bit rv32e);
    return rv32e ? 32'd16 : 32'd32;
  endfunction

endpackage

// File: rtl/ibex_register_file_fpga_bank.sv
// rtl/ibex_register_file_fpga_bank.sv - one LUT-RAM bank: single write port, async read ports
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  packed read addresses, port r at [AddrWidth*r +: AddrWidth]
//   rdata_o  packed read data, port r at [DataWidth*r +: DataWidth]
// No reset: contents are cleared by the clear sequencer in the top level.
module ibex_register_file_fpga_bank #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddrWidth    = 5,
  parameter int unsigned NumWords     = 32,
  parameter int unsigned NumReadPorts = 2
) (
  input  logic                              clk_i,
  input  logic                              we_i,
  input  logic [AddrWidth-1:0]              waddr_i,
  input  logic [DataWidth-1:0]              wdata_i,
  input  logic [NumReadPorts*AddrWidth-1:0] raddr_i,
  output logic [NumReadPorts*DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem [NumWords];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  for (genvar r = 0; r < NumReadPorts; r++) begin : g_rd
    assign rdata_o[DataWidth*r +: DataWidth] = mem[raddr_i[AddrWidth*r +: AddrWidth]];
  end

endmodule

// File: rtl/ibex_register_file_fpga_mp.sv
// rtl/ibex_register_file_fpga_mp.sv - multi-port FPGA register file with LVT and post-reset clear
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset, restarts the clear sequence
//   raddr_i  read addresses, port r at [5r +: 5]
//   rdata_o  read data, port r at [DataWidth*r +: DataWidth]
//   waddr_i  write addresses, port w at [5w +: 5]
//   wdata_i  write data, port w at [DataWidth*w +: DataWidth]
//   we_i     write enables
//   ready_o  clearing done, writes accepted
//   err_o    a bank write enable fired without its external we_i (WrenCheck)
// Optional macro IBEX_RF_FPGA_BYPASS_EN: same-cycle write-to-read forwarding in READY.
module ibex_register_file_fpga_mp
  import ibex_rf_fpga_pkg::*;
#(
  parameter bit                    RV32E         = 1'b0,
  parameter int unsigned           DataWidth     = 32,
  parameter int unsigned           NumReadPorts  = 2,
  parameter int unsigned           NumWritePorts = 1,
  parameter bit                    WrenCheck     = 1'b0,
  parameter logic [DataWidth-1:0]  WordZeroVal   = '0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumReadPorts*5-1:0]         raddr_i,
  output logic [NumReadPorts*DataWidth-1:0] rdata_o,
  input  logic [NumWritePorts*5-1:0]        waddr_i,
  input  logic [NumWritePorts*DataWidth-1:0] wdata_i,
  input  logic [NumWritePorts-1:0]          we_i,
  output logic                              ready_o,
  output logic                              err_o
);

  localparam int unsigned NUM_WORDS  = num_words(RV32E);
  localparam int unsigned ADDR_WIDTH = RV32E ? 4 : 5;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  rf_state_e state_q, state_d;
  addr_t     clr_cnt_q, clr_cnt_d;
  logic      clearing;

  addr_t                  wa [NumWritePorts];
  logic [DataWidth-1:0]   wd [NumWritePorts];
  logic [NumWritePorts-1:0] we_eff;
  logic [NumWritePorts-1:0] suppress;
  logic [NumWritePorts-1:0] bank_we;
  logic                   collide;

  addr_t                             ra [NumReadPorts];
  logic [NumReadPorts*ADDR_WIDTH-1:0] bank_raddr;
  logic [NumReadPorts*DataWidth-1:0]  bank_rdata [NumWritePorts];
  logic [NUM_WORDS-1:0]               lvt_q;

  // Clear sequencer: entry 0 is never stored, so counting starts at 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RF_CLEAR;
      clr_cnt_q <= addr_t'(1);
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == RF_CLEAR) begin
      clr_cnt_d = clr_cnt_q + addr_t'(1);
      if (clr_cnt_q == addr_t'(NUM_WORDS - 1)) begin
        state_d = RF_READY;
      end
    end
  end

  assign clearing = (state_q == RF_CLEAR);
  assign ready_o  = (state_q == RF_READY);

  // Write decode: RV32E simply drops the top address bit.
  for (genvar w = 0; w < NumWritePorts; w++) begin : g_wdec
    assign wa[w]     = waddr_i[RF_ADDR_W*w +: ADDR_WIDTH];
    assign wd[w]     = wdata_i[DataWidth*w +: DataWidth];
    assign we_eff[w] = ready_o && we_i[w] && (wa[w] != '0);
  end

  // Port 1 wins a same-address collision, so bank 0 is not written then.
  if (NumWritePorts == 2) begin : g_coll
    assign collide = we_eff[0] && we_eff[1] && (wa[0] == wa[1]);
  end else begin : g_nocoll
    assign collide = 1'b0;
  end

  assign suppress = NumWritePorts'(collide);
  assign bank_we  = clearing ? {NumWritePorts{1'b1}} : (we_eff & ~suppress);

  for (genvar r = 0; r < NumReadPorts; r++) begin : g_radr
    assign ra[r] = raddr_i[RF_ADDR_W*r +: ADDR_WIDTH];
    assign bank_raddr[ADDR_WIDTH*r +: ADDR_WIDTH] = ra[r];
  end

  for (genvar w = 0; w < NumWritePorts; w++) begin : g_bank
    ibex_register_file_fpga_bank #(
      .DataWidth    (DataWidth),
      .AddrWidth    (ADDR_WIDTH),
      .NumWords     (NUM_WORDS),
      .NumReadPorts (NumReadPorts)
    ) u_bank (
      .clk_i   (clk_i),
      .we_i    (bank_we[w]),
      .waddr_i (clearing ? clr_cnt_q : wa[w]),
      .wdata_i (clearing ? WordZeroVal : wd[w]),
      .raddr_i (bank_raddr),
      .rdata_o (bank_rdata[w])
    );
  end

  // Live-value table: remembers which bank holds the newest copy of each entry.
  if (NumWritePorts == 2) begin : g_lvt
    always_ff @(posedge clk_i) begin
      if (clearing) begin
        lvt_q[clr_cnt_q] <= 1'b0;
      end else begin
        if (we_eff[0] && !collide) lvt_q[wa[0]] <= 1'b0;
        if (we_eff[1])             lvt_q[wa[1]] <= 1'b1;
      end
    end
  end else begin : g_nolvt
    assign lvt_q = '0;
  end

  for (genvar r = 0; r < NumReadPorts; r++) begin : g_rmux
    logic [DataWidth-1:0] rd;
    always_comb begin
      rd = bank_rdata[lvt_q[ra[r]]][DataWidth*r +: DataWidth];
`ifdef IBEX_RF_FPGA_BYPASS_EN
      // Higher write port is applied last so it takes priority.
      for (int w = 0; w < NumWritePorts; w++) begin
        if (we_eff[w] && (wa[w] == ra[r])) rd = wd[w];
      end
`endif
      if (clearing || (ra[r] == '0)) rd = WordZeroVal;
    end
    assign rdata_o[DataWidth*r +: DataWidth] = rd;
  end

  if (WrenCheck) begin : g_wren
    assign err_o = ready_o && (|(bank_we & ~we_i));
  end else begin : g_nowren
    assign err_o = 1'b0;
  end

endmodule

// File: tb/tb_ibex_register_file_fpga_mp.sv
// tb/tb_ibex_register_file_fpga_mp.sv - scoreboard testbench for ibex_register_file_fpga_mp
module tb_ibex_register_file_fpga_mp;

  localparam logic [31:0] WZ = 32'h5A5A0000;
  localparam int K_RD0 = 0, K_RD1 = 1, K_RDY = 2, K_ERR = 3, K_RDYE = 4, K_RDE = 5;

`ifdef IBEX_RF_FPGA_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  raddr, waddr;
  logic [63:0] rdata, wdata;
  logic [1:0]  we;
  logic        ready, err;

  logic [4:0]  e_raddr, e_waddr;
  logic [31:0] e_rdata, e_wdata;
  logic [0:0]  e_we;
  logic        e_ready, e_err;

  always #5 clk = ~clk;

  ibex_register_file_fpga_mp #(
    .RV32E(1'b0), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2),
    .WrenCheck(1'b1), .WordZeroVal(WZ)
  ) dut (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .ready_o(ready), .err_o(err)
  );

  ibex_register_file_fpga_mp #(
    .RV32E(1'b1), .DataWidth(32), .NumReadPorts(1), .NumWritePorts(1),
    .WrenCheck(1'b0), .WordZeroVal(32'h0)
  ) dut_e (
    .clk_i(clk), .rst_i(rst), .raddr_i(e_raddr), .rdata_o(e_rdata),
    .waddr_i(e_waddr), .wdata_i(e_wdata), .we_i(e_we), .ready_o(e_ready), .err_o(e_err)
  );

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input int k, input logic [31:0] v, input string n);
    exp_t e;
    e.kind = k; e.exp = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_RD0:   act = rdata[31:0];
        K_RD1:   act = rdata[63:32];
        K_RDY:   act = {31'b0, ready};
        K_ERR:   act = {31'b0, err};
        K_RDYE:  act = {31'b0, e_ready};
        default: act = e_rdata;
      endcase
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  initial begin : stim
    int wait_cnt;
    rst = 1'b1; raddr = '0; waddr = '0; wdata = '0; we = '0;
    e_raddr = '0; e_waddr = '0; e_wdata = '0; e_we = '0;
    step();
    n_tests++;
    if ((ready !== 1'b0) || (err !== 1'b0) || (e_ready !== 1'b0) || (e_err !== 1'b0)) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b err=%b e_ready=%b e_err=%b at %0t",
               ready, err, e_ready, e_err, $time);
    end
    step();
    rst = 1'b0;

    raddr = {5'd0, 5'd5}; e_raddr = 5'd5;
    for (int i = 0; i <= 31; i++) begin
      if (i < 31) begin
        we = 2'b11; waddr = {5'd4, 5'd4}; wdata = {32'h1234, 32'h1234};
      end else begin
        we = 2'b00;
      end
      chk(K_RDY,  32'(i >= 31), "ready_clr");
      chk(K_RDYE, 32'(i >= 15), "ready_clr_rv32e");
      chk(K_RD0, WZ, "rd_clr_p0");
      chk(K_RD1, WZ, "rd_x0_p1");
      chk(K_ERR, 32'd0, "err_clr");
      chk(K_RDE, 32'd0, "rd_clr_rv32e");
      if (i < 31) step();
    end
    step();

    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'h0, 32'hDEADBEEF};
    raddr = {5'd4, 5'd5};
    chk(K_RD0, BYP ? 32'hDEADBEEF : WZ, "rd_same_cycle");
    chk(K_RD1, WZ, "we_ignored_in_clear");
    chk(K_ERR, 32'd0, "err_write");
    step();
    we = 2'b00;
    chk(K_RD0, 32'hDEADBEEF, "rd_after_write");

    step();
    we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22222222, 32'h11111111};
    chk(K_ERR, 32'd0, "err_collide");
    step();
    we = 2'b00; raddr = {5'd7, 5'd7};
    chk(K_RD0, 32'h22222222, "collide_p0");
    chk(K_RD1, 32'h22222222, "collide_p1");
    step();
    we = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'h0, 32'h33};
    chk(K_RD0, BYP ? 32'h33 : 32'h22222222, "rd7_same_cycle");
    step();
    we = 2'b00;
    chk(K_RD0, 32'h33, "lvt_back_p0");
    chk(K_RD1, 32'h33, "lvt_back_p1");

    step();
    we = 2'b11; waddr = {5'd9, 5'd8}; wdata = {32'hBBBB, 32'hAAAA};
    step();
    we = 2'b00; raddr = {5'd9, 5'd8};
    chk(K_RD0, 32'hAAAA, "dual_p0");
    chk(K_RD1, 32'hBBBB, "dual_p1");

    step();
    we = 2'b01; waddr = '0; wdata = {32'h0, 32'hA5A5A5A5}; raddr = '0;
    chk(K_ERR, 32'd0, "err_x0");
    chk(K_RD0, WZ, "x0_same_cycle");
    step();
    we = 2'b00;
    chk(K_RD0, WZ, "x0_after_write");

    e_we = 1'b1; e_waddr = 5'd21; e_wdata = 32'h77;
    step();
    e_we = 1'b0; e_raddr = 5'd5;
    chk(K_RDE, 32'h77, "rv32e_alias5");
    step();
    e_raddr = 5'd21;
    chk(K_RDE, 32'h77, "rv32e_alias21");

    step();
    we = 2'b00; waddr = '0;
    force dut.bank_we = 2'b01;
    #1;
    chk(K_ERR, 32'd1, "err_forced");
    step();
    release dut.bank_we;
    #1;
    chk(K_ERR, 32'd0, "err_released");

    step();
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'hCAFE};
    step();
    we = 2'b00; raddr = {5'd7, 5'd3};
    chk(K_RD0, 32'hCAFE, "fill3");
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i <= 31; i++) begin
      chk(K_RDY,  32'(i >= 31), "ready_restart");
      chk(K_RDYE, 32'(i >= 15), "ready_restart_rv32e");
      if (i == 31) begin
        chk(K_RD0, WZ, "addr3_cleared");
        chk(K_RD1, WZ, "addr7_cleared");
      end
      if (i < 31) step();
    end

    wait_cnt = 0;
    while (((ready !== 1'b1) || (e_ready !== 1'b1)) && (wait_cnt < 40)) begin
      step();
      wait_cnt++;
    end
    n_tests++;
    if ((ready !== 1'b1) || (e_ready !== 1'b1)) begin
      n_fail++;
      $display("FAIL ready_wait_expired: ready=%b e_ready=%b after %0d cycles at %0t",
               ready, e_ready, wait_cnt, $time);
    end

    step();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
